sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 121 ++++++++++++
 tb/tb_sipo_deserializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer: LSB-first framed bit stream assembled
// into WIDTH-bit words with a valid/ready output register and sticky overrun.
module sipo_deserializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;
  logic [WIDTH-1:0] word;
  logic             complete;

  // Frame assembly: bits enter at the MSB and move down, so after WIDTH
  // shifts the first serial bit lands in bit 0.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sreg_d   = sreg_q;
    complete = 1'b0;

    shifted             = sreg_q >> 1;
    shifted[WIDTH-1]    = in;
    fresh               = '0;
    fresh[WIDTH-1]      = in;
    word                = shifted;

    if (in_valid) begin
      if (start) begin
        // A start bit always begins a new frame, aborting any partial one.
        if (WIDTH == 1) begin
          complete = 1'b1;
          word     = fresh;
          sreg_d   = fresh;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          sreg_d  = fresh;
          count_d = CW'(1);
          state_d = SHIFT;
        end
      end else if (state_q == SHIFT) begin
        sreg_d = shifted;
        if (count_q == LAST) begin
          complete = 1'b1;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  // Output holding register: a completed word is dropped (and flagged) only
  // when the previous word is still pending and not being accepted.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sreg_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sreg_q      <= sreg_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH=4): directed scenarios plus
// random traffic, all compared against a queue-based frame model.
module tb_sipo_deserializer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in = 1'b0;
  logic         in_valid = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned words_seen = 0;

  // Reference model: bits of the frame in arrival order.
  bit           m_bits[$];
  bit           m_active = 0;
  logic [W-1:0] m_out = '0;
  bit           m_valid = 0;
  bit           m_ovr = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .start     (start),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit b, input bit v, input bit s, input bit rdy);
    bit           done;
    logic [W-1:0] word;
    done = 0;
    word = '0;
    if (r) begin
      m_bits.delete();
      m_active = 0;
      m_out    = '0;
      m_valid  = 0;
      m_ovr    = 0;
      return;
    end
    if (v) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(b);
        m_active = 1;
      end else if (m_active) begin
        m_bits.push_back(b);
      end
    end
    if (m_active && m_bits.size() == W) begin
      for (int i = 0; i < W; i++) word += (W'(m_bits[i]) << i);
      done = 1;
      m_active = 0;
      m_bits.delete();
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_out   = word;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit b, input bit v, input bit s, input bit rdy);
    reset = r; in = b; in_valid = v; start = s; out_ready = rdy;
    @(posedge clk);
    model_edge(r, b, v, s, rdy);
    #1;
    if (out_valid && out_ready) words_seen++;
    check("out", 32'(out), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_active));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit gaps, input bit rdy);
    for (int i = 0; i < W; i++) begin
      if (gaps) step(0, 0, 0, 0, rdy);
      step(0, word[i], 1, (i == 0), rdy);
    end
  endtask

  initial begin
    // Reset
    step(1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    check("rst_out", 32'(out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(overrun), 0);

    // Basic frame 1,0,1,1 -> 4'b1101
    step(0, 1, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    check("basic_out", 32'(out), 32'h0000_000D);
    check("basic_valid", 32'(out_valid), 1);
    step(0, 0, 0, 0, 1);
    check("basic_drop", 32'(out_valid), 0);

    // Ignored idle bit, then gapped frame 0,1,1,0 -> 4'b0110
    step(0, 1, 1, 0, 1);
    check("idle_ignore", 32'(busy), 0);
    send_frame(4'b0110, 1, 0);
    check("gap_out", 32'(out), 32'h6);
    step(0, 0, 0, 0, 1);

    // Backpressure: 3 then C with out_ready low
    send_frame(4'h3, 0, 0);
    send_frame(4'hC, 0, 0);
    check("bp_out", 32'(out), 32'h3);
    check("bp_ovr", 32'(overrun), 1);
    step(0, 0, 0, 0, 1);
    check("bp_valid", 32'(out_valid), 0);
    check("bp_ovr_sticky", 32'(overrun), 1);

    // Simultaneous accept and completion
    step(1, 0, 0, 0, 0);
    send_frame(4'hA, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    check("sim_out", 32'(out), 32'h5);
    check("sim_valid", 32'(out_valid), 1);
    check("sim_ovr", 32'(overrun), 0);
    step(0, 0, 0, 0, 1);

    // Resync: partial frame aborted by a new start
    words_seen = 0;
    step(0, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1);
    send_frame(4'hF, 0, 1);
    check("resync_out", 32'(out), 32'hF);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("resync_words", words_seen, 1);

    // Reset mid-frame with a pending word
    send_frame(4'h6, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    check("rst2_out", 32'(out), 0);
    check("rst2_valid", 32'(out_valid), 0);
    check("rst2_busy", 32'(busy), 0);
    send_frame(4'h9, 0, 0);
    check("post_rst_out", 32'(out), 32'h9);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(199) == 0), 1'($urandom), ($urandom_range(9) < 7),
           ($urandom_range(9) == 0), ($urandom_range(9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
